// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: state encoding, default polynomial and the LFSR step
// used by both the generator and the checker so the two ends cannot diverge.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'b00,
    ST_CONFIRM = 2'b01,
    ST_LOCKED  = 2'b10
  } prbs_state_e;

  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] PRBS_TAPS_DEFAULT = 8'hB8;

  function automatic logic [7:0] prbs_step(input logic [7:0] q, input logic [7:0] taps);
    return {q[6:0], ^(q & taps)};
  endfunction

endpackage

// File: rtl/prbs_err_counter.sv
// Saturating word-error counter; clear beats increment, reset beats both.
module prbs_err_counter #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_n,
  input  logic             inc,
  output logic [ERR_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (!clear_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + ERR_W'(1);
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: self-synchronises a local LFSR to the incoming word
// stream, then flywheels and counts mismatched words while locked.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_SEARCH  | waiting for a non-zero word to seed the local LFSR
//  ST_CONFIRM | seeded; counting consecutive correct predictions
//  ST_LOCKED  | flywheeling; mismatches flagged, counted, tracked for loss
module prbs_checker
  import prbs_pkg::*;
#(
  parameter logic [7:0] TAPS       = PRBS_TAPS_DEFAULT,
  parameter int         LOCK_COUNT = 4,
  parameter int         LOSS_COUNT = 3,
  parameter int         ERR_W      = 16
) (
  input  logic             BB_SYSTEM_CLOCK_50,
  input  logic             BB_SYSTEM_RESET_inHigh,
  input  logic             BB_SYSTEM_clear_InLow,
  input  logic [7:0]       rx_data_InBUS,
  input  logic             rx_valid_In,
  output logic             locked_Out,
  output logic             err_Out,
  output logic [ERR_W-1:0] err_count_OutBUS,
  output logic [1:0]       state_OutBUS
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_COUNT - 1);

  prbs_state_e   state_q, state_d;
  logic [7:0]    exp_q, exp_d;
  logic [MW-1:0] match_q, match_d;
  logic [LW-1:0] miss_q, miss_d;
  logic          err_q, err_d;
  logic          err_inc;

  always_ff @(posedge BB_SYSTEM_CLOCK_50) begin
    if (BB_SYSTEM_RESET_inHigh) begin
      state_q <= ST_SEARCH;
      exp_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    err_inc = 1'b0;
    if (rx_valid_In) begin
      case (state_q)
        ST_SEARCH: begin
          // all-zero is the LFSR lock-up value and can never seed a sequence
          if (rx_data_InBUS != '0) begin
            exp_d   = prbs_step(rx_data_InBUS, TAPS);
            match_d = '0;
            state_d = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (rx_data_InBUS == exp_q) begin
            exp_d = prbs_step(rx_data_InBUS, TAPS);
            if (match_q == MATCH_LAST) begin
              match_d = '0;
              miss_d  = '0;
              state_d = ST_LOCKED;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
            if (rx_data_InBUS != '0)
              exp_d = prbs_step(rx_data_InBUS, TAPS);
            else
              state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          // flywheel: prediction never reseeded from the data once locked
          exp_d = prbs_step(exp_q, TAPS);
          if (rx_data_InBUS == exp_q) begin
            miss_d = '0;
          end else begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            if (miss_q == MISS_LAST) begin
              miss_d  = '0;
              state_d = ST_SEARCH;
            end else begin
              miss_d = miss_q + LW'(1);
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  prbs_err_counter #(.ERR_W(ERR_W)) u_err_counter (
    .clk     (BB_SYSTEM_CLOCK_50),
    .rst     (BB_SYSTEM_RESET_inHigh),
    .clear_n (BB_SYSTEM_clear_InLow),
    .inc     (err_inc),
    .count   (err_count_OutBUS)
  );

  assign locked_Out   = (state_q == ST_LOCKED);
  assign err_Out      = err_q;
  assign state_OutBUS = state_q;

endmodule
